// File: rtl/serial_add.sv
// Bit-serial LSB-first adder: computes a + b + cin one bit per clock with a single full-adder
// cell, presenting the registered sum and carry-out with a one-cycle Done pulse.
module serial_add #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 cin,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 cout
);

  localparam int unsigned CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [DATAWIDTH-1:0] a_sr, b_sr, res_sr;
  logic                 carry;
  logic [CW-1:0]        cnt;

  logic                 bit_s, carry_d;
  logic [DATAWIDTH-1:0] res_d;

  // The single full-adder cell working on the current LSBs.
  always_comb begin
    bit_s   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_d = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    res_d   = {bit_s, res_sr[DATAWIDTH-1:1]};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state_q)
        // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
        StIdle, StDone: begin
          Done <= 1'b0;
          if (Start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry   <= cin;
            cnt     <= '0;
            res_sr  <= '0;
            Busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_d;
          res_sr <= res_d;
          if (cnt == LastBit) begin
            sum     <= res_d;
            cout    <= carry_d;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: directed corner cases plus random operands checked
// against plain integer addition.
module tb_serial_add;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         Busy, Done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  serial_add #(.DATAWIDTH(W)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Start(Start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .Busy (Busy),
    .Done (Done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 Clk = ~Clk;

  // Stimulus only: issue one request, then watch until Done (bounded), reporting what was seen.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       output int lat, output int busy_cnt,
                       output logic [W-1:0] osum, output logic ocout);
    @(negedge Clk);
    a = ia; b = ib; cin = icin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (Done === 1'b1) begin
        lat = k - 1;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
      @(negedge Clk);
    end
    osum = sum;
    ocout = cout;
  endtask

  task automatic test_reset;
    int lat, bc;
    logic [W-1:0] s;
    logic c;
    do_op(8'h12, 8'h34, 1'b0, lat, bc, s, c);
    total++;
    if ({c, s} !== 9'h046) begin
      bad++; $display("FAIL reset_preload: got %h want 046", {c, s});
    end
    // Start another run, then hit reset mid-cycle.
    @(negedge Clk); a = 8'hF0; b = 8'h0F; Start = 1'b1;
    @(posedge Clk); #3;
    Start = 1'b0;
    Rst = 1'b1;
    #1;
    total++;
    if ({Busy, Done, cout, sum} !== 11'h000) begin
      bad++; $display("FAIL reset_async: got busy=%b done=%b cout=%b sum=%h want all 0",
                      Busy, Done, cout, sum);
    end
    @(negedge Clk); Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      total++;
      if ({Busy, Done, cout, sum} !== 11'h000) begin
        bad++; $display("FAIL reset_idle cycle %0d: got busy=%b done=%b cout=%b sum=%h want 0",
                        i, Busy, Done, cout, sum);
      end
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [W-1:0] s;
    logic c;
    do_op(8'h7F, 8'h01, 1'b0, lat, bc, s, c);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
    total++;
    if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    total++;
    if ({c, s} !== 9'h080) begin bad++; $display("FAIL basic_sum: got %h want 080", {c, s}); end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done: got %b want 0", Busy); end
    @(negedge Clk);
    total++;
    if (Done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", Done); end
  endtask

  task automatic test_overflow;
    int lat, bc;
    logic [W-1:0] s;
    logic c;
    do_op(8'hFF, 8'h01, 1'b0, lat, bc, s, c);
    total++;
    if ({c, s} !== 9'h100) begin bad++; $display("FAIL ovf_ff_01: got %h want 100", {c, s}); end
    do_op(8'hFF, 8'hFF, 1'b1, lat, bc, s, c);
    total++;
    if ({c, s} !== 9'h1FF) begin bad++; $display("FAIL ovf_ff_ff_c: got %h want 1ff", {c, s}); end
  endtask

  task automatic test_ignore_busy;
    int lat;
    @(negedge Clk); a = 8'h10; b = 8'h20; cin = 1'b0; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk); a = 8'h55; b = 8'h55; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      if (Done === 1'b1) begin lat = k - 1; break; end
      @(negedge Clk);
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL ignore_latency: got %0d want 8", lat); end
    total++;
    if ({cout, sum} !== 9'h030) begin
      bad++; $display("FAIL ignore_sum: got %h want 030", {cout, sum});
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      total++;
      if ({Busy, Done} !== 2'b00) begin
        bad++; $display("FAIL ignore_no_second_run cycle %0d: got busy=%b done=%b want 0 0",
                        i, Busy, Done);
      end
    end
  endtask

  task automatic test_back_to_back;
    int first, second, k;
    @(negedge Clk); a = 8'h03; b = 8'h04; cin = 1'b0; Start = 1'b1;
    first = -1;
    second = -1;
    k = 0;
    while (k < 60 && second < 0) begin
      @(negedge Clk);
      k++;
      if (k == 2 && first < 0) Start = 1'b1;
      if (Done === 1'b1) begin
        if (first < 0) begin
          first = k;
          total++;
          if ({cout, sum} !== 9'h007) begin
            bad++; $display("FAIL b2b_first: got %h want 007", {cout, sum});
          end
          a = 8'h80; b = 8'h80; cin = 1'b0;
        end else begin
          second = k;
        end
      end else if (first > 0) begin
        Start = 1'b0;
        total++;
        if ({cout, sum} !== 9'h007) begin
          bad++; $display("FAIL b2b_hold at %0d: got %h want 007", k, {cout, sum});
        end
      end
    end
    Start = 1'b0;
    total++;
    if (second - first !== 9) begin
      bad++; $display("FAIL b2b_spacing: got %0d want 9", second - first);
    end
    total++;
    if ({cout, sum} !== 9'h100) begin
      bad++; $display("FAIL b2b_second: got %h want 100", {cout, sum});
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [W-1:0] ra, rb, s;
    logic rc, c;
    int unsigned expv;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      expv = int'(ra) + int'(rb) + int'(rc);
      do_op(ra, rb, rc, lat, bc, s, c);
      total++;
      if ({c, s} !== 9'(expv) || lat !== 8) begin
        bad++; $display("FAIL random %h+%h+%b: got %h lat %0d want %h lat 8",
                        ra, rb, rc, {c, s}, lat, 9'(expv));
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bc;
    logic [W-1:0] s;
    logic c;
    @(negedge Clk); a = 8'hAA; b = 8'h55; cin = 1'b0; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (5) @(negedge Clk);
    Rst = 1'b1;
    #1;
    total++;
    if ({Busy, Done, cout, sum} !== 11'h000) begin
      bad++; $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h want all 0",
                      Busy, Done, cout, sum);
    end
    @(negedge Clk); Rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      total++;
      if ({Done, cout, sum} !== 10'h000) begin
        bad++; $display("FAIL midrun_no_done cycle %0d: got done=%b cout=%b sum=%h want 0",
                        i, Done, cout, sum);
      end
    end
    do_op(8'h01, 8'h01, 1'b0, lat, bc, s, c);
    total++;
    if ({c, s} !== 9'h002 || lat !== 8) begin
      bad++; $display("FAIL midrun_recover: got %h lat %0d want 002 lat 8", {c, s}, lat);
    end
  endtask

  initial begin
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
